// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v raster counters and registered
// sync/blank decode with one-pixel lookahead coordinates for the grid stage.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        pix_en,
    output logic [31:0] next_x,
    output logic [31:0] next_y,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
    localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
    localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          vga_clk_q, vga_clk_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_n_q, blank_n_d;
    logic [31:0]   next_x_q, next_x_d;
    logic [31:0]   next_y_q, next_y_d;
    logic          frame_start_q, frame_start_d;
    logic          adv;
    logic [31:0]   h_cur, v_cur, h_new, v_new;

    always_comb begin
        adv   = (div_q == DIV_MAX);
        div_d = adv ? '0 : div_q + DW'(1);
        h_d   = h_q;
        v_d   = v_q;
        h_cur = 32'(h_q);
        v_cur = 32'(v_q);
        if (adv) begin
            if (h_cur == H_LAST) begin
                h_d = '0;
                v_d = (v_cur == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
        frame_start_d = adv && (h_cur == H_LAST) && (v_cur == V_LAST);

        // Decode from the values being loaded so outputs stay coherent with h/v.
        h_new     = 32'(h_d);
        v_new     = 32'(v_d);
        vga_clk_d = (div_d >= DIV_HALF);
        hsync_d   = !((h_new >= HS_START) && (h_new < HS_END));
        vsync_d   = !((v_new >= VS_START) && (v_new < VS_END));
        blank_n_d = (h_new < H_VIS) && (v_new < V_VIS);
        if (h_new == H_LAST) begin
            next_x_d = '0;
            next_y_d = (v_new == V_LAST) ? '0 : v_new + 32'd1;
        end else begin
            next_x_d = h_new + 32'd1;
            next_y_d = v_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            vga_clk_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b1;
            next_x_q      <= 32'd1;
            next_y_q      <= 32'd0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            vga_clk_q     <= vga_clk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            next_x_q      <= next_x_d;
            next_y_q      <= next_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en      = adv;
    assign vga_clk     = vga_clk_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign sync_n      = 1'b0;
    assign next_x      = next_x_q;
    assign next_y      = next_y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: expected raster state is derived from the
// count of clocks since reset; a negedge monitor compares every cycle.
module tb_vga_sync_gen;

    localparam int CD = 4;
    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_clk, hsync, vsync, blank_n, sync_n, pix_en, frame_start;
    logic [31:0] next_x, next_y;

    typedef struct {
        bit vclk;
        bit pe;
        bit hs;
        bit vs;
        bit bn;
        bit fs;
        int nx;
        int ny;
        int n;
    } exp_t;

    exp_t sb[$];
    int   n = 0;
    bit   have = 0;
    int   checks = 0;
    int   fails = 0;

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD)
    ) dut (
        .clk(clk), .rst(rst), .vga_clk(vga_clk), .hsync(hsync),
        .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
        .pix_en(pix_en), .next_x(next_x), .next_y(next_y),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // n = clock edges since the last reset edge; everything follows from it.
    function automatic exp_t model(input int cnt);
        exp_t e;
        int div, p, h, v, q;
        div = cnt % CD;
        p = (cnt / CD) % FR;
        h = p % HT;
        v = p / HT;
        q = (p + 1) % FR;
        e.vclk = (div >= CD / 2);
        e.pe = (div == CD - 1);
        e.hs = !(h >= HV + HF && h < HV + HF + HS);
        e.vs = !(v >= VV + VF && v < VV + VF + VS);
        e.bn = (h < HV) && (v < VV);
        e.fs = (cnt > 0) && (div == 0) && (p == 0);
        e.nx = q % HT;
        e.ny = q / HT;
        e.n = cnt;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int at);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at n=%0d: got %0d expected %0d", name, at, act, exp);
        end
    endtask

    task automatic cyc(input bit r);
        rst = r;
        @(posedge clk);
        if (r) n = 0;
        else n++;
        have |= r;
        if (have) sb.push_back(model(n));
        #1;
    endtask

    function automatic bit at_pix(input int cnt, input int h, input int v);
        return (cnt % CD == CD - 1) && ((cnt / CD) % FR == v * HT + h);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("vga_clk", int'(vga_clk), int'(e.vclk), e.n);
                chk("pix_en", int'(pix_en), int'(e.pe), e.n);
                chk("hsync", int'(hsync), int'(e.hs), e.n);
                chk("vsync", int'(vsync), int'(e.vs), e.n);
                chk("blank_n", int'(blank_n), int'(e.bn), e.n);
                chk("frame_start", int'(frame_start), int'(e.fs), e.n);
                chk("next_x", int'(next_x), e.nx, e.n);
                chk("next_y", int'(next_y), e.ny, e.n);
                chk("sync_n", int'(sync_n), 0, e.n);
            end
        end
    end

    initial begin : driver
        int guard;
        repeat (3) cyc(1'b1);
        repeat (3 * FR * CD) cyc(1'b0);
        // reset coincident with pix_en inside the hsync pulse, mid-frame
        guard = 0;
        while (!at_pix(n, HV + HF + 1, 2) && guard < FR * CD) begin
            cyc(1'b0);
            guard++;
        end
        chk("reach_mid_point", guard < FR * CD ? 1 : 0, 1, n);
        cyc(1'b1);
        repeat (FR * CD + 20) cyc(1'b0);
        // reset exactly on the wrap advance must suppress frame_start
        guard = 0;
        while (!at_pix(n, HT - 1, VT - 1) && guard < FR * CD) begin
            cyc(1'b0);
            guard++;
        end
        chk("reach_wrap_point", guard < FR * CD ? 1 : 0, 1, n);
        cyc(1'b1);
        repeat (FR * CD + 20) cyc(1'b0);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                repeat ($urandom_range(1, 3)) cyc(1'b1);
            end else begin
                cyc(1'b0);
            end
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0, n);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
